// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
// Every output comes straight from a flop, so neither ready nor data has a combinational path through the stage.
module pipe_skid_reg #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clock,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [1:0]   o_count
);

  // The encoding doubles as the occupancy count, so o_count needs no extra logic.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = i_valid & ready_q;
  assign out_fire = valid_q & i_ready;

  always_comb begin
    // NOTE: every signal gets a hold default before any branch, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (i_flush) begin
      // Flush wins over both handshakes. An out_fire in this cycle has already been taken downstream.
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = i_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = i_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    valid_d = (state_d != EMPTY);
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      // NOTE: the data registers are reset on purpose, because RESET_VAL has to appear on o_data as soon as reset asserts.
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here make every flop sample the pre-edge values, whatever the statement order.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_data  = main_q;
  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_count = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios followed by randomized traffic,
// checked against a queue-based model of an in-order 2-deep buffer.
module tb_pipe_skid_reg;

  localparam int          N  = 32;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic         clock = 1'b0;
  logic         i_rst_n;
  logic         i_flush;
  logic [N-1:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
  logic [1:0]   o_count;

  pipe_skid_reg #(.N(N), .RESET_VAL(RV)) dut (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  always #5 clock = ~clock;

  int           checks = 0;
  int           errors = 0;
  string        phase  = "init";
  // Reference: the buffer contents in order (head is on o_data). fresh means empty since reset or flush.
  logic [N-1:0] mq[$];
  bit           fresh  = 1'b1;
  bit           prev_stall = 1'b0;
  logic [N-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic r, input logic f);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
  endtask

  task automatic check_outputs();
    check("valid", 32'(o_valid), 32'(mq.size() != 0));
    check("ready", 32'(o_ready), 32'(mq.size() != 2));
    check("count", 32'(o_count), 32'(mq.size()));
    if (mq.size() != 0)
      check("data", o_data, mq[0]);
    else if (fresh)
      check("data_rst", o_data, RV);
  endtask

  // One cycle: compare before the edge, then advance the model by the rules of a 2-deep in-order buffer.
  task automatic tick();
    bit in_f;
    bit out_f;
    @(negedge clock);
    check_outputs();
    if (prev_stall) check("stable", o_data, prev_data);
    prev_stall = o_valid && !i_ready && !i_flush && i_rst_n;
    prev_data  = o_data;
    in_f  = i_valid && (mq.size() < 2);
    out_f = (mq.size() > 0) && i_ready;
    @(posedge clock);
    if (!i_rst_n || i_flush) begin
      mq.delete();
      fresh = 1'b1;
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(i_data);
      if (in_f || out_f) fresh = 1'b0;
    end
    #1;
  endtask

  task automatic fill_two(input logic [N-1:0] a, input logic [N-1:0] b);
    drive(1'b1, a, 1'b0, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0); tick();
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    phase = "reset";
    tick(); tick();
    i_rst_n = 1'b1;

    // Asynchronous reset with two entries held.
    phase = "async_rst";
    fill_two(32'h0000_00A1, 32'h0000_00B1);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    i_rst_n = 1'b0;
    #1;
    check("async_valid", 32'(o_valid), 32'd0);
    check("async_count", 32'(o_count), 32'd0);
    check("async_ready", 32'(o_ready), 32'd1);
    check("async_data", o_data, RV);
    mq.delete();
    fresh      = 1'b1;
    prev_stall = 1'b0;
    tick();
    i_rst_n = 1'b1;

    phase = "stream";
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick();

    phase = "backpressure";
    fill_two(32'h0000_000A, 32'h0000_000B);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("bp_count", 32'(o_count), 32'd2);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick(); tick();

    phase = "simultaneous";
    fill_two(32'h0000_000A, 32'h0000_000B);
    drive(1'b1, 32'h0000_000C, 1'b1, 1'b0);
    tick(); tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("sim_c_out", o_data, 32'h0000_000C);
    tick();

    phase = "flush";
    fill_two(32'h0000_000A, 32'h0000_000B);
    drive(1'b1, 32'h0000_000D, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick(); tick();

    phase = "random";
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 99) < 5));
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
